// File: rtl/io_fl_pkg.sv
// Shared sizing helpers and entry layout for the float-processor I/O bridge.
package io_fl_pkg;

  // Float word width: mantissa + exponent + sign.
  function automatic int word_w(input int nbmant, input int nbexpo);
    return nbmant + nbexpo + 1;
  endfunction

  // Address width for n locations; never narrower than one bit.
  function automatic int addr_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // Occupancy counter width able to hold 0..depth inclusive.
  function automatic int count_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  localparam int DEF_W   = word_w(16, 6);
  localparam int DEF_AOW = addr_w(8);

  // Output FIFO entry layout for the default configuration.
  typedef struct packed {
    logic [DEF_AOW-1:0] addr;
    logic [DEF_W-1:0]   data;
  } io_entry_t;

endpackage

// File: rtl/fifo_io_fl.sv
// Synchronous show-ahead FIFO; storage is register-based so reset clears it.
module fifo_io_fl
  import io_fl_pkg::*;
#(
  parameter  int DEPTH = 8,
  parameter  int WIDTH = 8,
  localparam int PW    = addr_w(DEPTH),
  localparam int CW    = count_w(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             do_push, do_pop;

  // A pop frees a slot in the same cycle, so a full FIFO still accepts a push.
  always_comb begin
    do_pop  = pop & ~empty;
    do_push = push & (~full | do_pop);
  end

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_mem
    // Each entry captures data when the write pointer targets it.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst)                                  mem_q[gi] <= '0;
      else if (do_push && wr_ptr_q == PW'(gi))   mem_q[gi] <= din;
    end
  end

  // Pointers wrap naturally on the power-of-two depth; count tracks exact occupancy.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign dout  = mem_q[rd_ptr_q];

endmodule

// File: rtl/io_bridge_fl.sv
// Peripheral responder for the float processor's I/O port: input holding
// registers on the read side, buffered output FIFO on the write side.
module io_bridge_fl
  import io_fl_pkg::*;
#(
  parameter  int NBMANT = 16,
  parameter  int NBEXPO = 6,
  parameter  int NUIOIN = 8,
  parameter  int NUIOOU = 8,
  parameter  int ODEPTH = 8,
  localparam int W      = word_w(NBMANT, NBEXPO),
  localparam int AIW    = addr_w(NUIOIN),
  localparam int AOW    = addr_w(NUIOOU),
  localparam int CW     = count_w(ODEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  output logic [W-1:0]      io_in,
  input  logic [AIW-1:0]    addr_in,
  input  logic              req_in,
  input  logic [W-1:0]      io_out,
  input  logic [AOW-1:0]    addr_out,
  input  logic              out_en,
  input  logic              src_wr,
  input  logic [AIW-1:0]    src_addr,
  input  logic [W-1:0]      src_data,
  output logic [NUIOIN-1:0] src_full,
  output logic              snk_valid,
  input  logic              snk_ready,
  output logic [AOW-1:0]    snk_addr,
  output logic [W-1:0]      snk_data,
  output logic [CW-1:0]     snk_count,
  output logic              ovf,
  output logic              udf,
  input  logic              clr_flags
);

  typedef struct packed {
    logic [AOW-1:0] addr;
    logic [W-1:0]   data;
  } entry_t;

  logic [W-1:0]      hold_q [NUIOIN];
  logic [W-1:0]      hold_d [NUIOIN];
  logic [NUIOIN-1:0] v_q, v_d;
  logic              ovf_q, ovf_d, udf_q, udf_d;
  logic              rd_ok, src_ok, rd_valid, udf_set, ovf_set;
  logic              snk_pop, fifo_full, fifo_empty;
  entry_t            fifo_din, fifo_dout;

  // Range checks use one extra bit so non-power-of-two address spaces work.
  always_comb begin
    rd_ok    = ({1'b0, addr_in}  < (AIW+1)'(NUIOIN));
    src_ok   = ({1'b0, src_addr} < (AIW+1)'(NUIOIN));
    rd_valid = 1'b0;
    io_in    = '0;
    if (rd_ok) begin
      rd_valid = v_q[addr_in];
      io_in    = hold_q[addr_in];
    end
  end

  for (genvar gi = 0; gi < NUIOIN; gi++) begin : g_hold
    logic wr_hit, rd_hit;
    // Producer write wins over consumption, so a same-cycle write leaves v set.
    always_comb begin
      wr_hit     = src_wr & src_ok & (src_addr == AIW'(gi));
      rd_hit     = req_in & rd_ok & (addr_in == AIW'(gi));
      hold_d[gi] = wr_hit ? src_data : hold_q[gi];
      v_d[gi]    = wr_hit ? 1'b1 : (rd_hit ? 1'b0 : v_q[gi]);
    end

    // Holding register and its valid bit.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        hold_q[gi] <= '0;
        v_q[gi]    <= 1'b0;
      end else begin
        hold_q[gi] <= hold_d[gi];
        v_q[gi]    <= v_d[gi];
      end
    end
  end

  // Sticky flags: a set event in the same cycle overrides clr_flags.
  always_comb begin
    snk_pop = snk_valid & snk_ready;
    udf_set = req_in & ~rd_valid;
    ovf_set = out_en & fifo_full & ~snk_pop;
    udf_d   = udf_set | (udf_q & ~clr_flags);
    ovf_d   = ovf_set | (ovf_q & ~clr_flags);
  end

  // Flag registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      udf_q <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      udf_q <= udf_d;
      ovf_q <= ovf_d;
    end
  end

  assign fifo_din = '{addr: addr_out, data: io_out};

  fifo_io_fl #(
    .DEPTH (ODEPTH),
    .WIDTH ($bits(entry_t))
  ) u_ofifo (
    .clk   (clk),
    .rst   (rst),
    .push  (out_en),
    .pop   (snk_pop),
    .din   (fifo_din),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (snk_count),
    .dout  (fifo_dout)
  );

  assign snk_valid = ~fifo_empty;
  assign snk_addr  = fifo_dout.addr;
  assign snk_data  = fifo_dout.data;
  assign src_full  = v_q;
  assign ovf       = ovf_q;
  assign udf       = udf_q;

endmodule

// File: tb/tb_io_bridge_fl.sv
// Self-checking bench for io_bridge_fl: input-side vector table plus an
// output-FIFO scoreboard driven cycle by cycle.
module tb_io_bridge_fl;

  localparam int W   = 23;
  localparam int AIW = 3;
  localparam int AOW = 3;
  localparam int CW  = 4;
  localparam int DEP = 8;

  logic           clk = 1'b0;
  logic           rst;
  logic [W-1:0]   io_in;
  logic [AIW-1:0] addr_in;
  logic           req_in;
  logic [W-1:0]   io_out;
  logic [AOW-1:0] addr_out;
  logic           out_en;
  logic           src_wr;
  logic [AIW-1:0] src_addr;
  logic [W-1:0]   src_data;
  logic [7:0]     src_full;
  logic           snk_valid;
  logic           snk_ready;
  logic [AOW-1:0] snk_addr;
  logic [W-1:0]   snk_data;
  logic [CW-1:0]  snk_count;
  logic           ovf;
  logic           udf;
  logic           clr_flags;

  io_bridge_fl dut (
    .clk(clk), .rst(rst), .io_in(io_in), .addr_in(addr_in), .req_in(req_in),
    .io_out(io_out), .addr_out(addr_out), .out_en(out_en), .src_wr(src_wr),
    .src_addr(src_addr), .src_data(src_data), .src_full(src_full),
    .snk_valid(snk_valid), .snk_ready(snk_ready), .snk_addr(snk_addr),
    .snk_data(snk_data), .snk_count(snk_count), .ovf(ovf), .udf(udf),
    .clr_flags(clr_flags)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic [AOW-1:0] addr;
    logic [W-1:0]   data;
  } ent_t;

  ent_t sb_q[$];
  logic m_ovf = 1'b0;

  typedef struct {
    logic           wr;
    logic [AIW-1:0] waddr;
    logic [W-1:0]   wdata;
    logic           req;
    logic [AIW-1:0] raddr;
    logic           clr;
    logic [W-1:0]   e_io;
    logic [7:0]     e_full;
    logic           e_udf;
  } vec_t;

  vec_t tbl[14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_idle();
    addr_in = '0; req_in = 1'b0; io_out = '0; addr_out = '0; out_en = 1'b0;
    src_wr = 1'b0; src_addr = '0; src_data = '0; snk_ready = 1'b0; clr_flags = 1'b0;
  endtask

  // Scoreboard step at the negedge: compare against the queue, then apply this cycle's traffic.
  task automatic sb_step();
    bit was_full, do_pop, ovf_ev;
    ent_t e;
    chk("snk_valid", 32'(snk_valid), 32'(sb_q.size() != 0));
    chk("snk_count", 32'(snk_count), 32'(sb_q.size()));
    chk("ovf", 32'(ovf), 32'(m_ovf));
    was_full = (sb_q.size() == DEP);
    do_pop   = snk_ready && (sb_q.size() != 0);
    ovf_ev   = 1'b0;
    if (do_pop) begin
      e = sb_q.pop_front();
      chk("snk_addr", 32'(snk_addr), 32'(e.addr));
      chk("snk_data", 32'(snk_data), 32'(e.data));
      $display("pop  addr=%0d data=0x%0h", snk_addr, snk_data);
    end
    if (out_en) begin
      if (!was_full || do_pop) sb_q.push_back('{addr: addr_out, data: io_out});
      else ovf_ev = 1'b1;
    end
    if (ovf_ev) m_ovf = 1'b1;
    else if (clr_flags) m_ovf = 1'b0;
  endtask

  task automatic cycle();
    @(negedge clk);
    sb_step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    set_idle();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 32'(snk_valid), 32'd0);
    chk("rst_count", 32'(snk_count), 32'd0);
    chk("rst_full",  32'(src_full),  32'd0);
    rst = 1'b1;

    // ---- reset mid-traffic: count 3, v = 8'h05 ----
    src_wr = 1'b1; src_addr = 3'd0; src_data = 23'h000ABC;
    out_en = 1'b1; addr_out = 3'd1; io_out = 23'h000011;
    cycle();
    src_addr = 3'd2; src_data = 23'h000DEF; addr_out = 3'd2; io_out = 23'h000022;
    cycle();
    src_wr = 1'b0; addr_out = 3'd3; io_out = 23'h000033;
    cycle();
    set_idle();
    chk("pre_rst_full",  32'(src_full),  32'h05);
    chk("pre_rst_count", 32'(snk_count), 32'd3);
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_io_in", 32'(io_in),     32'd0);
    chk("mid_rst_full",  32'(src_full),  32'd0);
    chk("mid_rst_valid", 32'(snk_valid), 32'd0);
    chk("mid_rst_count", 32'(snk_count), 32'd0);
    chk("mid_rst_addr",  32'(snk_addr),  32'd0);
    chk("mid_rst_data",  32'(snk_data),  32'd0);
    chk("mid_rst_flags", 32'({ovf, udf}), 32'd0);
    $display("mid-traffic reset applied");
    sb_q.delete();
    m_ovf = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;

    // ---- input-side vector table ----
    //             wr    waddr src_data      req   raddr clr   e_io          e_full  e_udf
    tbl[0]  = '{1'b1, 3'd2, 23'h1A5A5A, 1'b0, 3'd0, 1'b0, 23'h000000, 8'h00, 1'b0};
    tbl[1]  = '{1'b0, 3'd0, 23'h000000, 1'b1, 3'd2, 1'b0, 23'h1A5A5A, 8'h04, 1'b0};
    tbl[2]  = '{1'b0, 3'd0, 23'h000000, 1'b1, 3'd2, 1'b0, 23'h1A5A5A, 8'h00, 1'b0};
    tbl[3]  = '{1'b0, 3'd0, 23'h000000, 1'b0, 3'd2, 1'b0, 23'h1A5A5A, 8'h00, 1'b1};
    tbl[4]  = '{1'b0, 3'd0, 23'h000000, 1'b0, 3'd2, 1'b1, 23'h1A5A5A, 8'h00, 1'b1};
    tbl[5]  = '{1'b1, 3'd4, 23'h000222, 1'b0, 3'd0, 1'b0, 23'h000000, 8'h00, 1'b0};
    tbl[6]  = '{1'b1, 3'd4, 23'h000111, 1'b1, 3'd4, 1'b0, 23'h000222, 8'h10, 1'b0};
    tbl[7]  = '{1'b0, 3'd0, 23'h000000, 1'b1, 3'd4, 1'b0, 23'h000111, 8'h10, 1'b0};
    tbl[8]  = '{1'b0, 3'd0, 23'h000000, 1'b1, 3'd4, 1'b1, 23'h000111, 8'h00, 1'b0};
    tbl[9]  = '{1'b0, 3'd0, 23'h000000, 1'b0, 3'd4, 1'b0, 23'h000111, 8'h00, 1'b1};
    tbl[10] = '{1'b1, 3'd7, 23'h7FFFFF, 1'b0, 3'd7, 1'b0, 23'h000000, 8'h00, 1'b1};
    tbl[11] = '{1'b0, 3'd0, 23'h000000, 1'b0, 3'd7, 1'b1, 23'h7FFFFF, 8'h80, 1'b1};
    tbl[12] = '{1'b1, 3'd5, 23'h000055, 1'b1, 3'd5, 1'b0, 23'h000000, 8'h80, 1'b0};
    tbl[13] = '{1'b0, 3'd0, 23'h000000, 1'b0, 3'd5, 1'b0, 23'h000055, 8'hA0, 1'b1};
    for (int i = 0; i < 14; i++) begin
      src_wr = tbl[i].wr; src_addr = tbl[i].waddr; src_data = tbl[i].wdata;
      req_in = tbl[i].req; addr_in = tbl[i].raddr; clr_flags = tbl[i].clr;
      @(negedge clk);
      chk($sformatf("vec%0d_io_in", i),    32'(io_in),    32'(tbl[i].e_io));
      chk($sformatf("vec%0d_src_full", i), 32'(src_full), 32'(tbl[i].e_full));
      chk($sformatf("vec%0d_udf", i),      32'(udf),      32'(tbl[i].e_udf));
      $display("vec %0d: addr_in=%0d io_in=0x%0h src_full=0x%0h udf=%0b", i, addr_in, io_in, src_full, udf);
      sb_step();
      @(posedge clk);
      #1;
    end
    set_idle();
    clr_flags = 1'b1;
    cycle();
    set_idle();

    // ---- fill to ODEPTH, overflow, drain in order ----
    for (int k = 0; k < DEP; k++) begin
      out_en = 1'b1; addr_out = AOW'(k); io_out = W'(k);
      cycle();
      $display("push addr=%0d data=0x%0h", k, k);
    end
    chk("fill_count", 32'(snk_count), 32'd8);
    addr_out = 3'd0; io_out = 23'h000099;
    cycle();
    $display("push addr=0 data=0x99 (full)");
    set_idle();
    chk("ovf_after_drop", 32'(ovf), 32'd1);
    chk("count_after_drop", 32'(snk_count), 32'd8);
    snk_ready = 1'b1;
    for (int k = 0; k < DEP + 1; k++) cycle();
    chk("drained_valid", 32'(snk_valid), 32'd0);
    set_idle();
    clr_flags = 1'b1;
    cycle();
    set_idle();

    // ---- full FIFO with simultaneous push and pop, then wrap traffic ----
    for (int k = 0; k < DEP; k++) begin
      out_en = 1'b1; addr_out = AOW'(7 - k); io_out = W'(32'h40 + k);
      cycle();
    end
    snk_ready = 1'b1; addr_out = 3'd5; io_out = 23'h0005A5;
    cycle();
    chk("full_pushpop_count", 32'(snk_count), 32'd8);
    chk("full_pushpop_ovf", 32'(ovf), 32'd0);
    for (int k = 0; k < 20; k++) begin
      out_en = 1'b1; snk_ready = 1'b1;
      addr_out = AOW'(k); io_out = W'($urandom_range(0, 32'h7FFFFF));
      cycle();
    end
    out_en = 1'b0;
    for (int k = 0; k < DEP + 1; k++) cycle();
    chk("wrap_drained", 32'(snk_count), 32'd0);
    set_idle();

    // ---- flag clear, and set-beats-clear ----
    for (int k = 0; k < DEP; k++) begin
      out_en = 1'b1; addr_out = AOW'(k); io_out = W'(32'h70 + k);
      cycle();
    end
    io_out = 23'h000777; req_in = 1'b1; addr_in = 3'd6;
    cycle();
    set_idle();
    chk("both_flags_set", 32'({ovf, udf}), 32'b11);
    clr_flags = 1'b1;
    cycle();
    chk("both_flags_clr", 32'({ovf, udf}), 32'b00);
    clr_flags = 1'b1; req_in = 1'b1; addr_in = 3'd6;
    cycle();
    chk("udf_set_beats_clr", 32'(udf), 32'd1);
    set_idle();
    snk_ready = 1'b1;
    for (int k = 0; k < DEP + 1; k++) cycle();
    chk("final_empty", 32'(snk_valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/io_bridge_fl.md
# io_bridge_fl

Peripheral-side responder for the float processor's I/O port: it serves the processor's input reads (`req_in`/`addr_in`/`io_in`) and absorbs its output writes (`out_en`/`addr_out`/`io_out`). External producers load per-address input holding registers. External consumers drain a buffered output FIFO through a valid/ready handshake. It sits between `proc_fl` and the system fabric, so the processor never stalls on I/O.

## Interface
Parameters:
- `NBMANT`, 16, mantissa bits; word width W = NBMANT+NBEXPO+1
- `NBEXPO`, 6, exponent bits
- `NUIOIN`, 8, number of input addresses; AIW = $clog2(NUIOIN)
- `NUIOOU`, 8, number of output addresses; AOW = $clog2(NUIOOU)
- `ODEPTH`, 8, output FIFO depth in entries; power of two, ≥2

Ports:
- `clk`  in  1  sole clock; all state updates on the rising edge
- `rst`  in  1  asynchronous, active-low reset
- `io_in`  out  W  word returned to the processor
- `addr_in`  in  AIW  processor input address
- `req_in`  in  1  processor consumes input word at `addr_in`
- `io_out`  in  W  processor output word
- `addr_out`  in  AOW  processor output address
- `out_en`  in  1  processor output strobe
- `src_wr`  in  1  producer write strobe
- `src_addr`  in  AIW  producer target input address
- `src_data`  in  W  producer data
- `src_full`  out  NUIOIN  per-address "holding register valid" bitmap
- `snk_valid`  out  1  FIFO head available
- `snk_ready`  in  1  consumer accepts head
- `snk_addr`  out  AOW  head output address
- `snk_data`  out  W  head data
- `snk_count`  out  $clog2(ODEPTH)+1  FIFO occupancy
- `ovf`  out  1  sticky flag: processor write dropped because the FIFO was full
- `udf`  out  1  sticky flag: processor read an empty input address
- `clr_flags`  in  1  synchronous clear of `ovf` and `udf`

## Operation
- The input side has NUIOIN holding registers `hold[i]`, each W bits, plus a valid bit `v[i]`. `src_full` = `v`.
- `io_in` = `hold[addr_in]`, combinational. If `addr_in` ≥ NUIOIN, `io_in` = 0.
- On `src_wr` with `src_addr` < NUIOIN: `hold[src_addr]` ← `src_data` and `v` ← 1. A write to a valid register overwrites it; newest wins, and no flag is raised. Out-of-range writes are ignored.
- On `req_in`:
  - If `v[addr_in]` = 1, it is cleared.
  - If `v[addr_in]` = 0, `udf` is set and `hold` is unchanged, so the stale value is returned.
  - An out-of-range `req_in` sets `udf`.
- Same-cycle `src_wr` and `req_in` on the same address: the processor gets the old `hold` value, the new data is stored, and `v` ends at 1. If the address was empty, `udf` is still set and there is no bypass.
- The output side is a show-ahead FIFO of {`addr_out`, `io_out`}. `snk_valid` = (count ≠ 0). `snk_addr`/`snk_data` = head entry.
- Push on `out_en` if not full, or if full with a simultaneous pop. A push when full without a pop is dropped and sets `ovf`.
- Pop on `snk_valid & snk_ready`.
- Pointers wrap modulo ODEPTH. `snk_count` is exact, 0..ODEPTH.
- `clr_flags` clears the flags. A same-cycle set event takes priority over the clear.

## Timing
- Reset (`rst` = 0, async) clears all of the following:
  - `hold` = 0, `v` = 0, so `io_in` = 0 and `src_full` = 0
  - FIFO pointers and `snk_count` = 0, so `snk_valid` = 0
  - `snk_addr`/`snk_data` = 0, with FIFO storage cleared
  - `ovf` = `udf` = 0
- Reset mid-operation discards all buffered words; nothing is drained.
- Input read latency is 0 cycles (combinational mux). Consumption takes effect at the edge ending the `req_in` cycle.
- `src_wr` data is visible on `io_in` the cycle after the write edge.
- An `out_en` push into an empty FIFO raises `snk_valid` the next cycle. There is no write-through.
- Sustained throughput is one push and one pop per cycle.
- Flags update on the edge following the causing event.

## Structure
- Package `io_fl_pkg`: the word width function W(NBMANT,NBEXPO), the address-width helpers, and the FIFO entry struct {addr, data}.
- Sub-module `fifo_io_fl`: a synchronous show-ahead FIFO with parameters depth and width, providing push/pop/full/count. It is instantiated once for the output side.
- Holding registers and flags stay in the top module.

## Test plan
- Reset mid-traffic with FIFO count 3 and `v` = 8'h05 → all outputs 0, `snk_valid` = 0, `src_full` = 0 one cycle after `rst` asserts.
- `src_wr` addr 2, data 23'h1A5A5A; next cycle `addr_in` = 2, `req_in` = 1 → `io_in` = 23'h1A5A5A, `src_full[2]` cleared the next cycle, `udf` = 0. Repeating `req_in` on addr 2 → same data, `udf` = 1.
- Same-cycle `src_wr` addr 4 = 0x111 and `req_in` addr 4 while holding 0x222 → `io_in` = 0x222, then `hold[4]` = 0x111 and `v[4]` = 1.
- ODEPTH = 8 pushes (addr k, data k) with `snk_ready` = 0 → `snk_count` = 8. A 9th push → dropped, `ovf` = 1. Draining yields addr/data 0..7 in order, then `snk_valid` = 0.
- FIFO full plus simultaneous `out_en` and pop → push accepted, count stays 8, `ovf` stays 0. Continuous push/pop for 20 cycles exercises pointer wrap with ordering intact.
- `clr_flags` with `ovf` = `udf` = 1 → both cleared. `clr_flags` in the same cycle as a new underflow → `udf` = 1.
